// File: rtl/polaris_cpu.sv
// polaris_cpu: minimal RV64I-subset core, one instruction at a time through a
// multi-cycle FSM; unsupported encodings park the core in JAM until reset.
module polaris_cpu (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        jammed_o,
  input  logic        iack_i,
  input  logic [31:0] idat_i,
  output logic [63:0] iadr_o,
  output logic [1:0]  isiz_o,
  input  logic        dack_i,
  input  logic [63:0] ddat_i,
  output logic [63:0] ddat_o,
  output logic [63:0] dadr_o,
  output logic        dwe_o,
  output logic        dcyc_o,
  output logic        dstb_o,
  output logic [1:0]  dsiz_o,
  output logic        dsigned_o
);

  typedef enum logic [2:0] {S_RST, S_F, S_D, S_R, S_X, S_W, S_M, S_JAM} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_pc, r_a, r_b, r_res, r_adr;
  logic [31:0] r_ir;
  logic [63:0] r_rf [0:31];

  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [63:0] w_imm_i, w_imm_s, w_imm_u, w_rs1_val, w_rs2_val;
  logic [63:0] w_a, w_b, w_alu;
  logic [31:0] w_alu32;
  logic        w_is_opimm, w_is_opimm32, w_is_op, w_is_lui, w_is_auipc;
  logic        w_is_jalr, w_is_load, w_is_store, w_legal;

  assign w_opcode = r_ir[6:0];
  assign w_f3     = r_ir[14:12];
  assign w_f7     = r_ir[31:25];
  assign w_rd     = r_ir[11:7];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_imm_i  = {{52{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s  = {{52{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_u  = {{32{r_ir[31]}}, r_ir[31:12], 12'd0};

  assign w_is_opimm   = (w_opcode == 7'b0010011);
  assign w_is_opimm32 = (w_opcode == 7'b0011011);
  assign w_is_op      = (w_opcode == 7'b0110011);
  assign w_is_lui     = (w_opcode == 7'b0110111);
  assign w_is_auipc   = (w_opcode == 7'b0010111);
  assign w_is_jalr    = (w_opcode == 7'b1100111);
  assign w_is_load    = (w_opcode == 7'b0000011);
  assign w_is_store   = (w_opcode == 7'b0100011);

  // Every legal opcode ends in 2'b11, so a bad IR[1:0] falls out as illegal.
  always_comb begin
    w_legal = 1'b0;
    if (w_is_opimm) begin
      if (w_f3 == 3'b001)      w_legal = (r_ir[31:26] == 6'b000000);
      else if (w_f3 == 3'b101) w_legal = (r_ir[31:26] == 6'b000000) || (r_ir[31:26] == 6'b010000);
      else                     w_legal = 1'b1;
    end else if (w_is_opimm32) begin
      if (w_f3 == 3'b000)      w_legal = 1'b1;
      else if (w_f3 == 3'b001) w_legal = (w_f7 == 7'b0000000);
      else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
    end else if (w_is_op) begin
      w_legal = (w_f7 == 7'b0000000) ||
                ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    end else if (w_is_jalr) begin
      w_legal = (w_f3 == 3'b000);
    end else if (w_is_load) begin
      w_legal = (w_f3 != 3'b111);
    end else if (w_is_store) begin
      w_legal = ~w_f3[2];
    end else begin
      w_legal = w_is_lui | w_is_auipc;
    end
  end

  assign w_rs1_val = (w_rs1 == 5'd0) ? 64'd0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 64'd0 : r_rf[w_rs2];

  // R computes OP-IMM straight from the register file; X uses latched operands.
  assign w_a = (r_state == S_X) ? r_a : w_rs1_val;
  assign w_b = (r_state == S_X) ? r_b : w_imm_i;

  always_comb begin
    w_alu   = 64'd0;
    w_alu32 = 32'd0;
    if (w_is_opimm32) begin
      if (w_f3 == 3'b001)
        w_alu32 = w_a[31:0] << w_b[4:0];
      else if (w_f3 == 3'b101 && r_ir[30])
        w_alu32 = $signed(w_a[31:0]) >>> w_b[4:0];
      else if (w_f3 == 3'b101)
        w_alu32 = w_a[31:0] >> w_b[4:0];
      else
        w_alu32 = w_a[31:0] + w_b[31:0];
      w_alu = {{32{w_alu32[31]}}, w_alu32};
    end else begin
      case (w_f3)
        3'b000: w_alu = (w_is_op && r_ir[30]) ? (w_a - w_b) : (w_a + w_b);
        3'b001: w_alu = w_a << w_b[5:0];
        3'b010: w_alu = {63'd0, ($signed(w_a) < $signed(w_b))};
        3'b011: w_alu = {63'd0, (w_a < w_b)};
        3'b100: w_alu = w_a ^ w_b;
        3'b101: begin
          if (r_ir[30]) w_alu = $signed(w_a) >>> w_b[5:0];
          else          w_alu = w_a >> w_b[5:0];
        end
        3'b110: w_alu = w_a | w_b;
        default: w_alu = w_a & w_b;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_RST;
    else         r_state <= w_next;
  end

  // Handshakes: a fetch completes on the edge that samples iack_i high while
  // isiz_o = 2'b10; a data cycle completes on the edge that samples dack_i high
  // while dcyc_o/dstb_o are high. Request fields stay stable until that edge.
  always_comb begin
    w_next    = r_state;
    isiz_o    = 2'b00;
    dcyc_o    = 1'b0;
    dstb_o    = 1'b0;
    dwe_o     = 1'b0;
    dsiz_o    = 2'b00;
    dsigned_o = 1'b0;
    dadr_o    = 64'd0;
    ddat_o    = 64'd0;
    jammed_o  = 1'b0;
    case (r_state)
      S_RST: w_next = S_F;
      S_F: begin
        isiz_o = 2'b10;
        if (iack_i) w_next = S_D;
      end
      S_D: begin
        if (!w_legal)                   w_next = S_JAM;
        else if (w_is_lui || w_is_auipc) w_next = S_W;
        else                            w_next = S_R;
      end
      S_R: begin
        if (w_is_opimm || w_is_opimm32) w_next = S_W;
        else if (w_is_op || w_is_jalr)  w_next = S_X;
        else                            w_next = S_M;
      end
      S_X: w_next = S_W;
      S_W: w_next = S_F;
      S_M: begin
        dcyc_o    = 1'b1;
        dstb_o    = 1'b1;
        dwe_o     = w_is_store;
        dsiz_o    = w_f3[1:0];
        dsigned_o = w_is_load & ~w_f3[2];
        dadr_o    = r_adr;
        ddat_o    = r_b;
        if (dack_i) w_next = S_F;
      end
      default: jammed_o = 1'b1;
    endcase
  end

  assign iadr_o = r_pc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc <= 64'hFFFF_FFFF_FFFF_FF00;
    end else begin
      case (r_state)
        S_F: if (iack_i) begin
          r_ir <= idat_i;
          r_pc <= r_pc + 64'd4;
        end
        S_D: r_res <= w_is_auipc ? (r_pc - 64'd4 + w_imm_u) : w_imm_u;
        S_R: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_res <= w_alu;
          r_adr <= w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
        end
        S_X: r_res <= w_is_jalr ? r_pc : w_alu;
        S_W: if (w_is_jalr) r_pc <= r_adr;
        default: ;
      endcase
    end
  end

  // Register file is not reset; x0 is never written and reads as zero.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_rd != 5'd0) begin
      if (r_state == S_W)
        r_rf[w_rd] <= r_res;
      else if (r_state == S_M && dack_i && w_is_load)
        r_rf[w_rd] <= ddat_i;
    end
  end

endmodule

// File: tb/tb_polaris_cpu.sv
// Directed bench for polaris_cpu: acts as instruction and data slave, feeds a
// hand-assembled program and checks bus requests, cycle counts and JAM.
module tb_polaris_cpu;

  logic        clk = 1'b0;
  logic        reset_i, jammed_o, iack_i, dack_i, dwe_o, dcyc_o, dstb_o, dsigned_o;
  logic [31:0] idat_i;
  logic [63:0] iadr_o, ddat_i, ddat_o, dadr_o;
  logic [1:0]  isiz_o, dsiz_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fetch = 0;

  polaris_cpu dut (
    .clk_i(clk), .reset_i(reset_i), .jammed_o(jammed_o),
    .iack_i(iack_i), .idat_i(idat_i), .iadr_o(iadr_o), .isiz_o(isiz_o),
    .dack_i(dack_i), .ddat_i(ddat_i), .ddat_o(ddat_o), .dadr_o(dadr_o),
    .dwe_o(dwe_o), .dcyc_o(dcyc_o), .dstb_o(dstb_o), .dsiz_o(dsiz_o),
    .dsigned_o(dsigned_o)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "time limit");
  end

  // ---- checker ----
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check_val({tag, ":isiz"},  {62'd0, isiz_o}, 64'd0);
    check_val({tag, ":dcyc"},  {62'd0, dcyc_o, dstb_o}, 64'd0);
    check_val({tag, ":dwe"},   {62'd0, dwe_o, dsigned_o}, 64'd0);
    check_val({tag, ":dsiz"},  {62'd0, dsiz_o}, 64'd0);
    check_val({tag, ":dadr"},  dadr_o, 64'd0);
    check_val({tag, ":ddat"},  ddat_o, 64'd0);
  endtask

  // ---- drivers ----
  // Waits for a fetch request, checks address and spacing from the previous
  // fetch (gap = 0 skips that), holds off iack for 'waits' cycles, then accepts.
  task automatic fetch(input string tag, input logic [63:0] adr, input logic [31:0] ins,
                       input int gap, input int waits);
    int t;
    t = 0;
    while (isiz_o != 2'b10 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_val({tag, ":isiz"}, {62'd0, isiz_o}, 64'd2);
    check_val({tag, ":iadr"}, iadr_o, adr);
    if (gap > 0) check_val({tag, ":cycles"}, 64'(cyc - last_fetch), 64'(gap));
    last_fetch = cyc;
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1;
      check_val({tag, ":isiz_hold"}, {62'd0, isiz_o}, 64'd2);
      check_val({tag, ":iadr_hold"}, iadr_o, adr);
    end
    iack_i = 1'b1;
    idat_i = ins;
    @(posedge clk); #1;
    iack_i = 1'b0;
    idat_i = 32'd0;
  endtask

  // Serves one data cycle; it must open on the 4th cycle of the instruction.
  task automatic data_cycle(input string tag, input logic [63:0] adr, input logic [1:0] siz,
                            input logic sgn, input logic we, input logic [63:0] wdat,
                            input logic [63:0] rdat, input int waits);
    int t;
    t = 0;
    while (dcyc_o !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_val({tag, ":cyc_stb"}, {62'd0, dcyc_o, dstb_o}, 64'd3);
    check_val({tag, ":latency"}, 64'(cyc - last_fetch), 64'd3);
    check_val({tag, ":dadr"}, dadr_o, adr);
    check_val({tag, ":dsiz"}, {62'd0, dsiz_o}, {62'd0, siz});
    check_val({tag, ":dsigned"}, {63'd0, dsigned_o}, {63'd0, sgn});
    check_val({tag, ":dwe"}, {63'd0, dwe_o}, {63'd0, we});
    if (we) check_val({tag, ":ddat_o"}, ddat_o, wdat);
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1;
      check_val({tag, ":dcyc_hold"}, {63'd0, dcyc_o}, 64'd1);
      check_val({tag, ":dadr_hold"}, dadr_o, adr);
    end
    dack_i = 1'b1;
    ddat_i = rdat;
    @(posedge clk); #1;
    dack_i = 1'b0;
    ddat_i = 64'd0;
    check_val({tag, ":dcyc_drop"}, {63'd0, dcyc_o}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_bus({tag, ":in_reset"});
    check_val({tag, ":jammed"}, {63'd0, jammed_o}, 64'd0);
    reset_i = 1'b0;
    check_val({tag, ":first_cycle_isiz"}, {62'd0, isiz_o}, 64'd0);
    @(posedge clk); #1;
  endtask

  // ---- stimulus + scoreboard ----
  initial begin
    reset_i = 1'b1;
    iack_i  = 1'b0;
    idat_i  = 32'd0;
    dack_i  = 1'b0;
    ddat_i  = 64'd0;

    // Instruction word 0 is illegal: isiz drops in D, then JAM.
    do_reset("rst0");
    fetch("ill0", 64'hFFFF_FFFF_FFFF_FF00, 32'h0000_0000, 0, 2);
    check_val("ill0:d_isiz", {62'd0, isiz_o}, 64'd0);
    check_val("ill0:d_jammed", {63'd0, jammed_o}, 64'd0);
    @(posedge clk); #1;
    check_val("ill0:jammed", {63'd0, jammed_o}, 64'd1);
    check_idle_bus("ill0:jam_bus");
    repeat (3) @(posedge clk);
    #1;
    check_val("ill0:still_jammed", {63'd0, jammed_o}, 64'd1);

    do_reset("rst1");
    fetch("nop",      64'hFFFF_FFFF_FFFF_FF00, 32'h0000_0013, 0, 0);
    fetch("addi_x2",  64'hFFFF_FFFF_FFFF_FF04, 32'h1240_0113, 4, 0);
    fetch("jalr_x2",  64'hFFFF_FFFF_FFFF_FF08, 32'h0001_0067, 4, 0);
    fetch("addi_x2b", 64'h0000_0000_0000_0124, 32'h1241_0113, 5, 0);
    fetch("jalr_x1",  64'h0000_0000_0000_0128, 32'h0001_00E7, 4, 0);
    fetch("jalr_m4",  64'h0000_0000_0000_0248, 32'hFFC0_8067, 5, 0);
    fetch("addi_x3",  64'h0000_0000_0000_0128, 32'h0010_0193, 5, 0);
    fetch("slliw",    64'h0000_0000_0000_012C, 32'h01F1_919B, 4, 0);
    fetch("jalr_x3",  64'h0000_0000_0000_0130, 32'h0001_8067, 4, 0);
    fetch("lui_x6",   64'hFFFF_FFFF_8000_0000, 32'h5555_B337, 5, 0);
    fetch("addi_x6",  64'hFFFF_FFFF_8000_0004, 32'hAAA3_0313, 3, 0);
    fetch("slli_x6",  64'hFFFF_FFFF_8000_0008, 32'h0103_1313, 4, 0);
    fetch("addi_m1",  64'hFFFF_FFFF_8000_000C, 32'hFFF0_0113, 4, 0);
    fetch("xor",      64'hFFFF_FFFF_8000_0010, 32'h0061_4133, 4, 0);
    fetch("jalr_odd", 64'hFFFF_FFFF_8000_0014, 32'h0001_0067, 5, 0);
    fetch("lui_x2",   64'hFFFF_AAAA_5555_FFFF, 32'hDEAD_B137, 5, 0);
    fetch("jalr_lui", 64'hFFFF_AAAA_5556_0003, 32'h0001_0067, 3, 0);
    fetch("nop2",     64'hFFFF_FFFF_DEAD_B000, 32'h0000_0013, 5, 0);
    fetch("auipc",    64'hFFFF_FFFF_DEAD_B004, 32'h0052_4297, 4, 0);
    fetch("jalr_x5",  64'hFFFF_FFFF_DEAD_B008, 32'hFFC2_8067, 3, 0);
    fetch("lhu",      64'hFFFF_FFFF_DEFF_F000, 32'h1231_5083, 5, 0);
    data_cycle("lhu", 64'hFFFF_FFFF_DEAD_B123, 2'b01, 1'b0, 1'b0, 64'd0, 64'h0000_0000_0000_FFFC, 2);
    fetch("lb",       64'hFFFF_FFFF_DEFF_F004, 32'h0040_8083, 6, 0);
    data_cycle("lb",  64'h0000_0000_0001_0000, 2'b00, 1'b1, 1'b0, 64'd0, 64'h0000_0000_0000_FFFC, 0);
    fetch("sd",       64'hFFFF_FFFF_DEFF_F008, 32'h0010_B623, 4, 0);
    data_cycle("sd",  64'h0000_0000_0001_0008, 2'b11, 1'b0, 1'b1, 64'h0000_0000_0000_FFFC, 64'd0, 1);
    fetch("srai",     64'hFFFF_FFFF_DEFF_F00C, 32'h4041_5413, 5, 0);
    fetch("sltu",     64'hFFFF_FFFF_DEFF_F010, 32'h0080_B4B3, 4, 0);
    fetch("sub",      64'hFFFF_FFFF_DEFF_F014, 32'h4094_0533, 5, 0);
    fetch("sd_x10",   64'hFFFF_FFFF_DEFF_F018, 32'h00A0_3023, 5, 0);
    data_cycle("sd_x10", 64'd0, 2'b11, 1'b0, 1'b1, 64'hFFFF_FFFF_FDEA_DAFF, 64'd0, 0);

    // Reset in the middle of a load's bus cycle must drop it immediately.
    fetch("ld_abort", 64'hFFFF_FFFF_DEFF_F01C, 32'h0000_3583, 4, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("ld_abort:in_m", {62'd0, dcyc_o, dstb_o}, 64'd3);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check_idle_bus("ld_abort:reset");
    reset_i = 1'b0;
    @(posedge clk); #1;

    // JAL is not supported and must jam.
    fetch("jal", 64'hFFFF_FFFF_FFFF_FF00, 32'h0000_006F, 0, 0);
    check_val("jal:d_jammed", {63'd0, jammed_o}, 64'd0);
    @(posedge clk); #1;
    check_val("jal:jammed", {63'd0, jammed_o}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
